// File: rtl/lsu_ctrl.sv
// Load/store unit: word-aligned data memory access with load extension,
// sub-word stores by read-modify-write, and access-error reporting.
module lsu_ctrl #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        acc_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  state_t      state, next_state;
  logic [31:0] cap_addr;
  logic [15:0] cap_data;
  logic [2:0]  cap_f3;
  logic [31:0] rmw_buf;

  logic        f3_bad, misaligned, out_of_range, req_err, start_rmw;
  logic [32:0] size_m1, last_byte;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, merged;

  // Access checks; 33-bit sum so addresses near 2^32 cannot wrap into range.
  always_comb begin
    f3_bad  = 1'b0;
    size_m1 = 33'd0;
    case (req_funct3[1:0])
      2'b00:   size_m1 = 33'd0;
      2'b01:   size_m1 = 33'd1;
      2'b10:   size_m1 = 33'd3;
      default: f3_bad  = 1'b1;
    endcase
    if (req_we ? req_funct3[2] : (req_funct3[2] && req_funct3[1]))
      f3_bad = 1'b1;
    misaligned   = (size_m1[0] && req_addr[0]) || (size_m1[1] && req_addr[1]);
    last_byte    = {1'b0, req_addr} + size_m1;
    out_of_range = last_byte >= 33'(MEM_BYTES);
    req_err      = f3_bad || misaligned || out_of_range;
  end

  always_comb begin
    ld_byte = mem_rd[{req_addr[1:0], 3'b000} +: 8];
    ld_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (req_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = mem_rd;
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = 32'd0;
    endcase
  end

  always_comb begin
    merged = rmw_buf;
    if (cap_f3 == 3'b001)
      merged[{cap_addr[1], 4'b0000} +: 16] = cap_data;
    else
      merged[{cap_addr[1:0], 3'b000} +: 8] = cap_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_addr <= 32'd0;
      cap_data <= 16'd0;
      cap_f3   <= 3'd0;
      rmw_buf  <= 32'd0;
    end else begin
      state <= next_state;
      if (start_rmw) begin
        cap_addr <= req_addr;
        cap_data <= req_wdata[15:0];
        cap_f3   <= req_funct3;
      end
      if (state == RMW_RD)
        rmw_buf <= mem_rd;
    end
  end

  // Outputs are forced low while reset is held, even with a request pending.
  always_comb begin
    next_state = state;
    start_rmw  = 1'b0;
    load_data  = 32'd0;
    stall      = 1'b0;
    done       = 1'b0;
    acc_err    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wd     = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            done    = 1'b1;
            acc_err = 1'b1;
          end else if (!req_we) begin
            mem_read  = 1'b1;
            mem_addr  = {req_addr[31:2], 2'b00};
            load_data = ld_ext;
            done      = 1'b1;
          end else if (req_funct3 == 3'b010) begin
            mem_write = 1'b1;
            mem_addr  = {req_addr[31:2], 2'b00};
            mem_wd    = req_wdata;
            done      = 1'b1;
          end else begin
            start_rmw  = 1'b1;
            stall      = 1'b1;
            next_state = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        mem_addr   = {cap_addr[31:2], 2'b00};
        mem_read   = 1'b1;
        stall      = 1'b1;
        next_state = RMW_WR;
      end
      RMW_WR: begin
        mem_addr   = {cap_addr[31:2], 2'b00};
        mem_write  = 1'b1;
        mem_wd     = merged;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (!rst_n) begin
      start_rmw = 1'b0;
      load_data = 32'd0;
      stall     = 1'b0;
      done      = 1'b0;
      acc_err   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'd0;
      mem_wd    = 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed RV32I loads/stores against a
// bench-owned word memory; expected responses are queued and a monitor checks them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] load_data, mem_addr, mem_wd, mem_rd;
  logic        stall, done, acc_err, mem_read, mem_write;

  typedef struct packed {
    logic        is_load;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;

  lsu_ctrl #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_data(load_data), .stall(stall), .done(done), .acc_err(acc_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[9:2]];

  always @(posedge clk)
    if (mem_write) mem[mem_addr[9:2]] <= mem_wd;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expected response per done pulse and checks invariants each cycle.
  always @(negedge clk) begin
    resp_t r;
    checkOutput("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
    checkOutput("err_without_done", {31'd0, acc_err & ~done}, 32'd0);
    if (mem_write) begin
      wr_count++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wd;
    end
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        checkOutput("acc_err", {31'd0, acc_err}, {31'd0, r.err});
        if (r.is_load || r.err)
          checkOutput("load_data", load_data, r.data);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_data, input logic exp_err,
                               input int exp_stall);
    int  stalls = 0;
    bit  got = 0;
    resp_t r;
    r.is_load = ~we;
    r.err     = exp_err;
    r.data    = exp_data;
    exp_q.push_back(r);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) got = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    checkOutput("stall_cycles", stalls, exp_stall);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h80FF_7F01;
    mem[4] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: reset during RMW_RD discards the sub-word store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    checkOutput("t1_rmw_rd_read", {31'd0, mem_read}, 32'd1);
    checkOutput("t1_rmw_rd_stall", {31'd0, stall}, 32'd1);
    w0 = wr_count;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_outputs_in_reset",
      {31'd0, |{load_data, stall, done, acc_err, mem_read, mem_write, mem_addr, mem_wd}}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t1_idle_stall", {31'd0, stall}, 32'd0);
    checkOutput("t1_idle_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("t1_no_write", wr_count - w0, 32'd0);
    checkOutput("t1_word_kept", mem[4], 32'h1122_3344);
    @(posedge clk); #1;

    // T2: loads with sign/zero extension
    applyStimulus(1'b0, 3'b000, 32'h3, 32'd0, 32'hFFFF_FF80, 1'b0, 0);
    applyStimulus(1'b0, 3'b100, 32'h3, 32'd0, 32'h0000_0080, 1'b0, 0);
    applyStimulus(1'b0, 3'b001, 32'h2, 32'd0, 32'hFFFF_80FF, 1'b0, 0);
    applyStimulus(1'b0, 3'b101, 32'h2, 32'd0, 32'h0000_80FF, 1'b0, 0);
    applyStimulus(1'b0, 3'b000, 32'h1, 32'd0, 32'h0000_007F, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h0, 32'd0, 32'h80FF_7F01, 1'b0, 0);

    // T3: SB via read-modify-write
    w0 = wr_count;
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h1234_56AA, 32'd0, 1'b0, 2);
    checkOutput("t3_write_count", wr_count - w0, 32'd1);
    checkOutput("t3_mem_addr", last_wr_addr, 32'h10);
    checkOutput("t3_mem_wd", last_wr_data, 32'h1122_AA44);
    checkOutput("t3_word", mem[4], 32'h1122_AA44);

    // T4: misaligned and illegal funct3
    w0 = wr_count;
    applyStimulus(1'b1, 3'b001, 32'h13, 32'hFFFF, 32'd0, 1'b1, 0);
    applyStimulus(1'b0, 3'b010, 32'h2, 32'd0, 32'd0, 1'b1, 0);
    applyStimulus(1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 1'b1, 0);
    applyStimulus(1'b1, 3'b100, 32'h0, 32'd0, 32'd0, 1'b1, 0);
    checkOutput("t4_no_write", wr_count - w0, 32'd0);
    checkOutput("t4_word", mem[4], 32'h1122_AA44);

    // T5: range boundary
    applyStimulus(1'b1, 3'b010, 32'h3FC, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    checkOutput("t5_top_word", mem[255], 32'hDEAD_BEEF);
    w0 = wr_count;
    applyStimulus(1'b1, 3'b010, 32'h400, 32'h0BAD_0BAD, 32'd0, 1'b1, 0);
    applyStimulus(1'b0, 3'b001, 32'h3FF, 32'd0, 32'd0, 1'b1, 0);
    applyStimulus(1'b0, 3'b100, 32'h3FF, 32'd0, 32'h0000_00DE, 1'b0, 0);
    checkOutput("t5_no_write", wr_count - w0, 32'd0);
    checkOutput("t5_word0", mem[0], 32'h80FF_7F01);
    checkOutput("t5_top_kept", mem[255], 32'hDEAD_BEEF);

    // T6: SH upper half then an immediate LW of the same word
    applyStimulus(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 32'd0, 1'b0, 2);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'd0, 32'hBEEF_0000, 1'b0, 0);

    @(posedge clk); #1;
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
